// File: rtl/uart_rsp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_rsp_pkg
// Brief    : Shared types and constants for the UART register responder.
// Revision : 1.0 - initial release
// ============================================================================
package uart_rsp_pkg;

    // FSM encoding; ST_GET_CSUM is only reachable in checksum builds
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_GET_DATA = 3'd1,
        ST_GET_CSUM = 3'd2,
        ST_WRITE    = 3'd3,
        ST_READ_REQ = 3'd4,
        ST_READ_CAP = 3'd5,
        ST_SEND     = 3'd6,
        ST_WAIT_TX  = 3'd7
    } state_t;

    localparam logic [7:0] c_ACK    = 8'hAA;
    localparam logic [7:0] c_NAK    = 8'h55;
    localparam int         c_RW_BIT = 7;

    // Width of the inter-byte timeout counter
    function automatic int timer_width(input int cycles);
        return $clog2(cycles);
    endfunction

    // Header bits between the address field and the RW bit must be zero
    function automatic logic addr_legal(input logic [7:0] hdr, input int aw);
        return (((hdr & 8'h7F) >> aw) == 8'h00);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_reg_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_reg_responder_if
// Brief    : UART byte ports plus register bus seen by the responder.
//            slave = responder side, master = UART / register file side.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_reg_responder_if #(
    parameter int AddrWidth = 4
);
    logic [7:0]           rx_data_i;
    logic                 rx_done_tick_i;
    logic                 tx_done_tick_i;
    logic [7:0]           tx_data_o;
    logic                 tx_start_o;
    logic [AddrWidth-1:0] reg_addr_o;
    logic [7:0]           reg_wdata_o;
    logic                 reg_wr_en_o;
    logic                 reg_rd_en_o;
    logic [7:0]           reg_rdata_i;
    logic                 busy_o;
    logic                 frame_err_o;

    modport slave (
        input  rx_data_i, rx_done_tick_i, tx_done_tick_i, reg_rdata_i,
        output tx_data_o, tx_start_o, reg_addr_o, reg_wdata_o,
               reg_wr_en_o, reg_rd_en_o, busy_o, frame_err_o
    );

    modport master (
        output rx_data_i, rx_done_tick_i, tx_done_tick_i, reg_rdata_i,
        input  tx_data_o, tx_start_o, reg_addr_o, reg_wdata_o,
               reg_wr_en_o, reg_rd_en_o, busy_o, frame_err_o
    );
endinterface
`default_nettype wire

// File: rtl/uart_rsp_timer.sv
`default_nettype none
// ============================================================================
// Module   : uart_rsp_timer
// Brief    : Inter-byte timeout counter. Counts while enabled, restarts on
//            clear, and pulses o_expire on the cycle it reaches the limit.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rsp_timer
    import uart_rsp_pkg::*;
#(
    parameter int TimeoutCycles = 1000000
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_clear,
    input  wire logic i_enable,
    output logic      o_expire
);
    localparam int                 c_CNT_W = timer_width(TimeoutCycles);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(TimeoutCycles - 1);

    logic [c_CNT_W-1:0] r_cnt;

    // A clear in the same cycle masks expiry so an arriving byte always wins
    assign o_expire = i_enable && !i_clear && (r_cnt == c_LAST);

    // Counter runs only while enabled and restarts after every clear/expiry
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clear || !i_enable || o_expire) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
endmodule
`default_nettype wire

// File: rtl/uart_reg_responder.sv
`default_nettype none
// ============================================================================
// Module   : uart_reg_responder
// Brief    : Decodes host read/write frames from UART bytes, drives the
//            register bus and answers through the UART transmitter.
//            Optional macro UART_RSP_CHECKSUM_EN adds a trailing XOR checksum
//            to every request and a second XOR byte to every response.
// Revision : 1.0 - initial release
// ============================================================================
module uart_reg_responder
    import uart_rsp_pkg::*;
#(
    parameter int AddrWidth     = 4,
    parameter int TimeoutCycles = 1000000
) (
    input  wire logic           clk_i,
    input  wire logic           rst_i,
    uart_reg_responder_if.slave bus
);
    state_t               r_state, w_state_nxt;
    logic                 r_ok, w_ok;
    logic [AddrWidth-1:0] r_addr, w_addr;
    logic [7:0]           r_wdata, w_wdata;
    logic [7:0]           r_tx_data, w_tx_data;
    logic                 r_tx_start, r_wr_en, r_rd_en, r_busy, r_frame_err;
    logic                 w_frame_err;
    logic                 w_tmr_en, w_rx_accept, w_rx_drop, w_expire;
`ifdef UART_RSP_CHECKSUM_EN
    logic                 r_is_wr, w_is_wr;
    logic [7:0]           r_hdr, w_hdr;
    logic [7:0]           r_csum, w_csum;
    logic                 r_second, w_second;
`endif

    // Bytes are only accepted while idle or collecting a frame; others drop
    always_comb begin
        w_tmr_en    = (r_state == ST_GET_DATA) || (r_state == ST_GET_CSUM);
        w_rx_accept = bus.rx_done_tick_i && (w_tmr_en || (r_state == ST_IDLE));
        w_rx_drop   = bus.rx_done_tick_i && !w_rx_accept;
    end

    uart_rsp_timer #(
        .TimeoutCycles (TimeoutCycles)
    ) u_timer (
        .clk      (clk_i),
        .rst      (rst_i),
        .i_clear  (w_rx_accept),
        .i_enable (w_tmr_en),
        .o_expire (w_expire)
    );

    // Next-state and next-output-value decode
    always_comb begin
        w_state_nxt = r_state;
        w_ok        = r_ok;
        w_addr      = r_addr;
        w_wdata     = r_wdata;
        w_tx_data   = r_tx_data;
        w_frame_err = 1'b0;
`ifdef UART_RSP_CHECKSUM_EN
        w_is_wr     = r_is_wr;
        w_hdr       = r_hdr;
        w_csum      = r_csum;
        w_second    = r_second;
`endif
        case (r_state)
            ST_IDLE: begin
                if (bus.rx_done_tick_i) begin
                    w_ok   = addr_legal(bus.rx_data_i, AddrWidth);
                    w_addr = bus.rx_data_i[AddrWidth-1:0];
`ifdef UART_RSP_CHECKSUM_EN
                    w_is_wr     = bus.rx_data_i[c_RW_BIT];
                    w_hdr       = bus.rx_data_i;
                    w_csum      = bus.rx_data_i;
                    w_second    = 1'b0;
                    w_state_nxt = bus.rx_data_i[c_RW_BIT] ? ST_GET_DATA : ST_GET_CSUM;
`else
                    w_state_nxt = bus.rx_data_i[c_RW_BIT] ? ST_GET_DATA : ST_READ_REQ;
`endif
                end
            end
            ST_GET_DATA: begin
                if (bus.rx_done_tick_i) begin
                    w_wdata = bus.rx_data_i;
`ifdef UART_RSP_CHECKSUM_EN
                    w_csum      = r_csum ^ bus.rx_data_i;
                    w_state_nxt = ST_GET_CSUM;
`else
                    w_state_nxt = ST_WRITE;
`endif
                end else if (w_expire) begin
                    w_state_nxt = ST_IDLE;
                    w_frame_err = 1'b1;
                end
            end
`ifdef UART_RSP_CHECKSUM_EN
            ST_GET_CSUM: begin
                if (bus.rx_done_tick_i) begin
                    w_ok        = r_ok && (bus.rx_data_i == r_csum);
                    w_state_nxt = r_is_wr ? ST_WRITE : ST_READ_REQ;
                end else if (w_expire) begin
                    w_state_nxt = ST_IDLE;
                    w_frame_err = 1'b1;
                end
            end
`endif
            ST_WRITE: begin
                w_tx_data   = r_ok ? c_ACK : c_NAK;
                w_frame_err = !r_ok;
                w_state_nxt = ST_SEND;
            end
            ST_READ_REQ: begin
                w_state_nxt = ST_READ_CAP;
            end
            ST_READ_CAP: begin
                w_tx_data   = r_ok ? bus.reg_rdata_i : c_NAK;
                w_frame_err = !r_ok;
                w_state_nxt = ST_SEND;
            end
            ST_SEND: begin
                w_state_nxt = ST_WAIT_TX;
            end
            ST_WAIT_TX: begin
                if (bus.tx_done_tick_i) begin
`ifdef UART_RSP_CHECKSUM_EN
                    if (!r_second) begin
                        w_second    = 1'b1;
                        w_tx_data   = r_tx_data ^ r_hdr;
                        w_state_nxt = ST_SEND;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
`else
                    w_state_nxt = ST_IDLE;
`endif
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register and registered outputs; strobes derive from next state
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= ST_IDLE;
            r_ok        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= 8'h00;
            r_tx_data   <= 8'h00;
            r_tx_start  <= 1'b0;
            r_wr_en     <= 1'b0;
            r_rd_en     <= 1'b0;
            r_busy      <= 1'b0;
            r_frame_err <= 1'b0;
`ifdef UART_RSP_CHECKSUM_EN
            r_is_wr     <= 1'b0;
            r_hdr       <= 8'h00;
            r_csum      <= 8'h00;
            r_second    <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_ok        <= w_ok;
            r_addr      <= w_addr;
            r_wdata     <= w_wdata;
            r_tx_data   <= w_tx_data;
            r_tx_start  <= (w_state_nxt == ST_SEND);
            r_wr_en     <= (w_state_nxt == ST_WRITE) && w_ok;
            r_rd_en     <= (w_state_nxt == ST_READ_REQ) && w_ok;
            r_busy      <= (w_state_nxt != ST_IDLE);
            r_frame_err <= w_frame_err || w_rx_drop;
`ifdef UART_RSP_CHECKSUM_EN
            r_is_wr     <= w_is_wr;
            r_hdr       <= w_hdr;
            r_csum      <= w_csum;
            r_second    <= w_second;
`endif
        end
    end

    assign bus.tx_data_o   = r_tx_data;
    assign bus.tx_start_o  = r_tx_start;
    assign bus.reg_addr_o  = r_addr;
    assign bus.reg_wdata_o = r_wdata;
    assign bus.reg_wr_en_o = r_wr_en;
    assign bus.reg_rd_en_o = r_rd_en;
    assign bus.busy_o      = r_busy;
    assign bus.frame_err_o = r_frame_err;
endmodule
`default_nettype wire

// File: doc/uart_reg_responder.md
# uart_reg_responder

Byte-level command responder on the far side of the UART link. It consumes received bytes from the UART receiver, decodes host read/write frames, and drives a simple register bus. It answers each frame through the UART transmitter's start/done handshake. It sits between `uart_ip` (rx/tx byte ports) and a user register file, and turns the UART into a host-controlled register access port.

## Interface
- `AddrWidth`, 4: register address bits taken from header bits [AddrWidth-1:0]; legal range 1..7.
- `TimeoutCycles`, 1000000: inter-byte timeout in `clk_i` cycles; must be ≥2.
- `clk_i`  in  1  single clock; all logic rising-edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `rx_data_i`  in  8  received byte; valid when `rx_done_tick_i`=1.
- `rx_done_tick_i`  in  1  one-cycle pulse per received byte.
- `tx_done_tick_i`  in  1  one-cycle pulse when the transmitter finishes a byte.
- `tx_data_o`  out  8  byte to transmit; held stable from `tx_start_o` until `tx_done_tick_i`.
- `tx_start_o`  out  1  one-cycle transmit request.
- `reg_addr_o`  out  AddrWidth  register address.
- `reg_wdata_o`  out  8  write data.
- `reg_wr_en_o`  out  1  one-cycle write strobe.
- `reg_rd_en_o`  out  1  one-cycle read strobe; `reg_rdata_i` is valid the following cycle.
- `reg_rdata_i`  in  8  read data.
- `busy_o`  out  1  high whenever the FSM is not in IDLE.
- `frame_err_o`  out  1  one-cycle pulse on protocol error.

## Operation
- Frame header: bit7 = 1 write, 0 read; bits[6:AddrWidth] must be 0, otherwise the address is illegal.
- Write frame: header, data. Response: ACK 8'hAA.
- Read frame: header. Response: register byte.
- Illegal address: the frame is still fully received (data byte consumed for writes). No bus strobe is issued. Response is NAK 8'h55, plus a `frame_err_o` pulse.
- FSM states: IDLE, GET_DATA, GET_CSUM (only with checksum), WRITE, READ_REQ, READ_CAP, SEND, WAIT_TX.
- Transitions:
  - IDLE → GET_DATA (write header) or READ_REQ (read header), on `rx_done_tick_i`.
  - GET_DATA → WRITE.
  - WRITE → SEND.
  - READ_REQ → READ_CAP → SEND.
  - SEND → WAIT_TX.
  - WAIT_TX → IDLE (or SEND for the next response byte) on `tx_done_tick_i`.
- Timeout: the counter is cleared on every accepted byte and counts only in GET_DATA/GET_CSUM. On reaching TimeoutCycles-1 the FSM goes to IDLE, pulses `frame_err_o`, and sends no response.
- A byte arriving in WRITE/READ_*/SEND/WAIT_TX is dropped and pulses `frame_err_o` (the host is half-duplex).
- A byte tick in the same cycle as timeout expiry: the byte wins and the timeout is ignored.
- `rst_i` mid-frame or mid-response: the FSM returns to IDLE and any pending `tx_done_tick_i` is ignored.

## Timing
- Reset values:
  - all strobes 0
  - `tx_data_o`=0, `reg_addr_o`=0, `reg_wdata_o`=0
  - `busy_o`=0, FSM=IDLE, timeout counter=0
- Write: data tick at cycle N → `reg_wr_en_o` at N+1 → `tx_start_o` at N+2.
- Read: header tick at cycle N → `reg_rd_en_o` at N+1 → `reg_rdata_i` captured at N+2 → `tx_start_o` at N+3.
- `reg_addr_o`/`reg_wdata_o` are registered at header/data acceptance and hold until the next frame.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `UART_RSP_CHECKSUM_EN` defined:
  - Every request frame carries a trailing XOR checksum byte over all preceding frame bytes.
  - A mismatch suppresses the register strobe and responds NAK with a `frame_err_o` pulse.
  - Every response is followed by a second byte: XOR of the response byte and the request header.
- Undefined: no checksum bytes in either direction; GET_CSUM and the second SEND/WAIT_TX pass are not built.

## Structure
- `uart_rsp_pkg`: state encoding, ACK=8'hAA, NAK=8'h55, RW bit index 7, timeout counter width `$clog2(TimeoutCycles)`.
- One sub-module, `uart_rsp_timer`:
  - Inputs: clear, enable.
  - Output: expire pulse.
  - Parameter: TimeoutCycles.

## Test plan
- Write 0x83, 0x5C → `reg_wr_en_o` pulse with addr 3 / data 0x5C at N+1; `tx_data_o`=0xAA, `tx_start_o` at N+2.
- Read 0x03 with `reg_rdata_i`=0x5C → `reg_rd_en_o` at N+1; `tx_data_o`=0x5C, `tx_start_o` at N+3.
- Header 0x90 (illegal with AddrWidth=4), then 0x11 → no `reg_wr_en_o`; NAK 0x55 sent; `frame_err_o` pulse.
- Header 0x81, then no byte for TimeoutCycles cycles → `frame_err_o` pulse, FSM in IDLE, no `tx_start_o`; a following read frame is answered normally.
- Byte tick during WAIT_TX → `frame_err_o` pulse, byte ignored, response completes.
- With `UART_RSP_CHECKSUM_EN`: frame 0x82, 0x10, 0x92 → write occurs, then 0xAA and 0x28 are sent. With checksum 0x00 instead of 0x92 → NAK 0x55 then 0xD7, no write.
